// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a show-ahead FIFO with overrun/framing pulses.
// Define UART_RX_FIFO_FRAMING_CHECK_EN to drop bytes whose stop bit samples low.
module uart_rx_fifo #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD = 115200,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     uartrx,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  input  logic                     rd_en,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overrun,
  output logic                     framing_err
);
  localparam int CLK_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF = (CLK_PER_BIT - 1) / 2;
  localparam int CW = $clog2(CLK_PER_BIT) + 1;
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      sh_q, sh_d;
  logic [1:0]      sync_q;
  logic            overrun_q, framing_err_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic [7:0]      mem [DEPTH];
  logic            inp, at_half, at_end, stop_smp, push, pop, wr_ok;

  assign inp     = sync_q[1];
  assign at_half = cnt_q == CW'(HALF);
  assign at_end  = cnt_q == CW'(CLK_PER_BIT - 1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    idx_d    = idx_q;
    sh_d     = sh_q;
    stop_smp = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!inp) state_d = START;
      end
      START: if (at_half) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = inp ? IDLE : DATA;
      end
      DATA: if (at_end) begin
        cnt_d       = '0;
        sh_d[idx_q] = inp;
        idx_d       = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = STOP;
      end
      STOP: if (at_end) begin
        cnt_d    = '0;
        stop_smp = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef UART_RX_FIFO_FRAMING_CHECK_EN
  assign push = stop_smp && inp;
`else
  assign push = stop_smp;
`endif

  assign rd_valid = count_q != '0;
  assign full     = count_q == (AW+1)'(DEPTH);
  assign pop      = rd_en && rd_valid;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign wr_ok    = push && (!full || pop);
  assign count_d  = (wr_ok && !pop) ? count_q + (AW+1)'(1) :
                    (pop && !wr_ok) ? count_q - (AW+1)'(1) : count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      sh_q          <= '0;
      sync_q        <= 2'b11;
      overrun_q     <= 1'b0;
      framing_err_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      sh_q          <= sh_d;
      sync_q        <= {sync_q[0], uartrx};
      overrun_q     <= push && full && !pop;
      framing_err_q <= stop_smp && !inp;
      wr_ptr_q      <= wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_q      <= pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= sh_q;
  end

  assign rd_data     = mem[rd_ptr_q];
  assign count       = count_q;
  assign overrun     = overrun_q;
  assign framing_err = framing_err_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed checks of the buffered UART receiver.
// Runs at 16 clocks per bit (CLK_FREQ = 16*BAUD) to keep frames short.
module tb_uart_rx_fifo;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uartrx = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid, full, overrun, framing_err;
  logic [4:0] count;
  int checks = 0, errors = 0, ovr_n = 0, fe_n = 0;

  uart_rx_fifo #(.CLK_FREQ(115200*CPB), .BAUD(115200), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .uartrx(uartrx), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_en(rd_en), .count(count), .full(full), .overrun(overrun), .framing_err(framing_err)
  );

  always #5 clk = ~clk;

  // Pulse counters: one increment per clock cycle the pulse is high.
  always @(posedge clk) begin
    if (overrun) ovr_n++;
    if (framing_err) fe_n++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bitp(input logic v, input int n);
    uartrx = v;
    repeat (n) @(negedge clk);
  endtask

  // Stop is sampled on the posedge between the 10th and 11th negedge of the stop bit.
  task automatic send(input logic [7:0] d, input logic stop = 1'b1, input logic pop_at_stop = 1'b0);
    bitp(1'b0, CPB);
    for (int i = 0; i < 8; i++) bitp(d[i], CPB);
    bitp(stop, 10);
    rd_en = pop_at_stop;
    @(negedge clk);
    rd_en = 1'b0;
    uartrx = 1'b1;
    repeat (CPB - 11) @(negedge clk);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    check(tag, rd_data, exp);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_valid", rd_valid, 0);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_overrun", overrun, 0);
    check("rst_framing", framing_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    send(8'h55);
    send(8'hA3);
    check("two_valid", rd_valid, 1);
    check("two_count", count, 2);
    pop_chk("pop_55", 8'h55);
    pop_chk("pop_a3", 8'hA3);
    check("two_drained_count", count, 0);
    check("two_drained_valid", rd_valid, 0);

    bitp(1'b0, 4);
    bitp(1'b1, 40);
    check("glitch_count", count, 0);
    check("glitch_fe", fe_n, 0);
    check("glitch_ovr", ovr_n, 0);
    send(8'h3C);
    check("after_glitch_count", count, 1);
    pop_chk("pop_3c", 8'h3C);

    for (int i = 0; i < 16; i++) send(8'(i));
    check("fill_ovr", ovr_n, 0);
    check("fill_full", full, 1);
    check("fill_count", count, 16);
    send(8'h10);
    check("overrun_pulse", ovr_n, 1);
    check("overrun_count", count, 16);
    check("overrun_head", rd_data, 8'h00);

    send(8'h99, 1'b1, 1'b1);
    check("popfull_ovr", ovr_n, 1);
    check("popfull_count", count, 16);
    check("popfull_full", full, 1);
    for (int i = 1; i < 16; i++) pop_chk("drain", 8'(i));
    pop_chk("drain_last", 8'h99);
    check("drain_count", count, 0);
    check("drain_valid", rd_valid, 0);

    send(8'hA3, 1'b0);
    bitp(1'b1, 40);
    check("framing_pulse", fe_n, 1);
    check("framing_ovr", ovr_n, 1);
`ifdef UART_RX_FIFO_FRAMING_CHECK_EN
    check("framing_count", count, 0);
`else
    check("framing_count", count, 1);
    pop_chk("framing_data", 8'hA3);
`endif

    for (int i = 0; i < 5; i++) send(8'h20 + 8'(i));
    check("pre_reset_count", count, 5);
    bitp(1'b0, CPB);
    for (int i = 0; i < 4; i++) bitp(1'(i % 2), CPB);
    bitp(1'b0, CPB / 2);
    rst_n = 1'b0;
    #1;
    check("mid_reset_count", count, 0);
    check("mid_reset_valid", rd_valid, 0);
    check("mid_reset_full", full, 0);
    uartrx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_reset_count", count, 0);
    send(8'h7E);
    check("post_reset_one", count, 1);
    pop_chk("pop_7e", 8'h7E);
    check("post_reset_empty", rd_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
